// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result handshake bundle for serial_adder.
//   master : operand source + result consumer (drives in_valid, a, b, cin,
//            sub, out_ready; observes in_ready, out_valid, sum, cout, ovf)
//   slave  : the adder itself (mirror of master)
interface serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract of two WIDTH-bit operands,
// BITS_PER_CYCLE bits per clock through a ripple of full-adder slices with a
// registered carry between cycles.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : serial_adder_if.slave
//            in_valid/in_ready   operand handshake (a, b, cin, sub)
//            out_valid/out_ready result handshake (sum, cout, ovf)
//   sub=0 : sum = a + b + cin,  cout = carry out
//   sub=1 : sum = a - b - cin,  cout = NOT borrow out
//   ovf   : two's-complement overflow (carry into MSB ^ carry out of MSB)
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one slice of BITS_PER_CYCLE bits per edge, N edges total
// DONE  | result held with out_valid=1 until out_ready
module serial_adder #(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic          clk,
   input logic          rst_n,
   serial_adder_if.slave bus
);

   localparam int N   = WIDTH / BITS_PER_CYCLE;
   localparam int CW  = $clog2(N) + 1;
   localparam int SBW = $clog2(WIDTH) + 1;

   if (WIDTH < 2) begin : g_bad_width
      $error("serial_adder: WIDTH must be >= 2");
   end
   if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
      $error("serial_adder: BITS_PER_CYCLE must divide WIDTH");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic                      last_slice;
   logic [SBW-1:0]            slice_base;
   logic [WIDTH-1:0]          a_sh;
   logic [WIDTH-1:0]          b_sh;
   logic [BITS_PER_CYCLE-1:0] slice_sum;
   logic                      carry_next;
   logic                      carry_msb;
   logic [WIDTH-1:0]          sum_next;

   assign last_slice = (cnt_q == CW'(N - 1));
   assign slice_base = SBW'(cnt_q) * SBW'(BITS_PER_CYCLE);

   // Shift the current slice down to bit 0 instead of using a variable
   // part-select; keeps index widths independent of the parameters.
   assign a_sh = a_q >> slice_base;
   assign b_sh = b_q >> slice_base;

   always_comb begin
      logic c;
      slice_sum = '0;
      carry_msb = carry_q;
      c         = carry_q;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         // carry into the top bit of the slice; on the last slice that is the
         // carry into the operand MSB, needed for the overflow flag
         if (i == BITS_PER_CYCLE - 1) begin
            carry_msb = c;
         end
         slice_sum[i] = a_sh[i] ^ b_sh[i] ^ c;
         c            = (a_sh[i] & b_sh[i]) | (c & (a_sh[i] ^ b_sh[i]));
      end
      carry_next = c;
   end

   always_comb begin
      logic [WIDTH-1:0] mask;
      mask     = WIDTH'({BITS_PER_CYCLE{1'b1}}) << slice_base;
      sum_next = (sum_q & ~mask) | ((WIDTH'(slice_sum) << slice_base) & mask);
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (bus.in_valid) state_d = CALC;
         CALC: if (last_slice) state_d = DONE;
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // output logic
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state_q)
         IDLE: bus.in_ready = 1'b1;
         CALC: ;
         DONE: bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

   // datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  // subtraction as a + ~b + ~cin
                  a_q     <= bus.a;
                  b_q     <= bus.sub ? ~bus.b : bus.b;
                  carry_q <= bus.sub ? ~bus.cin : bus.cin;
                  cnt_q   <= '0;
               end
            end
            CALC: begin
               sum_q   <= sum_next;
               carry_q <= carry_next;
               cnt_q   <= cnt_q + CW'(1);
               if (last_slice) begin
                  cout_q <= carry_next;
                  ovf_q  <= carry_msb ^ carry_next;
               end
            end
            DONE: ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   logic clk;
   logic rst_n;

   serial_adder_if #(.WIDTH(8)) if1 ();
   serial_adder_if #(.WIDTH(8)) if4 ();

   serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_bpc1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1)
   );

   serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_bpc4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if4)
   );

   int n_checks = 0;
   int n_fail   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // in_ready and out_valid must never be high together
   always @(negedge clk) begin
      if (rst_n) begin
         check("excl_bpc1", {31'd0, if1.in_ready & if1.out_valid}, 32'd0);
         check("excl_bpc4", {31'd0, if4.in_ready & if4.out_valid}, 32'd0);
      end
   end

   task automatic drive(input int w, input logic v, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb);
      if (w == 1) begin
         if1.in_valid = v; if1.a = av; if1.b = bv; if1.cin = ci; if1.sub = sb;
      end else begin
         if4.in_valid = v; if4.a = av; if4.b = bv; if4.cin = ci; if4.sub = sb;
      end
   endtask

   task automatic set_ordy(input int w, input logic r);
      if (w == 1) if1.out_ready = r;
      else        if4.out_ready = r;
   endtask

   task automatic get(input int w, output logic ir, output logic ov, output logic [7:0] s,
                      output logic co, output logic of);
      if (w == 1) begin
         ir = if1.in_ready; ov = if1.out_valid; s = if1.sum; co = if1.cout; of = if1.ovf;
      end else begin
         ir = if4.in_ready; ov = if4.out_valid; s = if4.sum; co = if4.cout; of = if4.ovf;
      end
   endtask

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   // Accepts one operand set and waits for the result; leaves the block in DONE.
   task automatic start_and_wait(input int w, input vec_t v, input string tag);
      logic ir, ov, co, of;
      logic [7:0] s;
      int lat;
      get(w, ir, ov, s, co, of);
      check({tag, "_in_ready_idle"}, {31'd0, ir}, 32'd1);
      drive(w, 1'b1, v.a, v.b, v.cin, v.sub);
      @(posedge clk); #1;
      // garbage operands after accept must not disturb the result
      drive(w, 1'b0, ~v.a, v.b ^ 8'h5A, ~v.cin, ~v.sub);
      lat = 0;
      get(w, ir, ov, s, co, of);
      while (!ov && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         get(w, ir, ov, s, co, of);
      end
      check({tag, "_latency"}, lat, (w == 1) ? 32'd8 : 32'd2);
      check({tag, "_sum"},  {24'd0, s}, {24'd0, v.sum});
      check({tag, "_cout"}, {31'd0, co}, {31'd0, v.cout});
      check({tag, "_ovf"},  {31'd0, of}, {31'd0, v.ovf});
   endtask

   task automatic consume(input int w, input string tag);
      logic ir, ov, co, of;
      logic [7:0] s;
      drive(w, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      set_ordy(w, 1'b1);
      @(posedge clk); #1;
      set_ordy(w, 1'b0);
      get(w, ir, ov, s, co, of);
      check({tag, "_out_valid_after"}, {31'd0, ov}, 32'd0);
      check({tag, "_in_ready_after"},  {31'd0, ir}, 32'd1);
   endtask

   vec_t vecs[8];

   initial begin
      logic ir, ov, co, of;
      logic [7:0] s;
      int seen;

      vecs[0] = '{a:8'hFF, b:8'h01, cin:1'b0, sub:1'b0, sum:8'h00, cout:1'b1, ovf:1'b0};
      vecs[1] = '{a:8'h7F, b:8'h01, cin:1'b0, sub:1'b0, sum:8'h80, cout:1'b0, ovf:1'b1};
      vecs[2] = '{a:8'h80, b:8'hFF, cin:1'b0, sub:1'b0, sum:8'h7F, cout:1'b1, ovf:1'b1};
      vecs[3] = '{a:8'h05, b:8'h07, cin:1'b0, sub:1'b1, sum:8'hFE, cout:1'b0, ovf:1'b0};
      vecs[4] = '{a:8'h05, b:8'h03, cin:1'b1, sub:1'b1, sum:8'h01, cout:1'b1, ovf:1'b0};
      vecs[5] = '{a:8'hFF, b:8'hFF, cin:1'b1, sub:1'b0, sum:8'hFF, cout:1'b1, ovf:1'b0};
      vecs[6] = '{a:8'h3C, b:8'h5A, cin:1'b0, sub:1'b0, sum:8'h96, cout:1'b0, ovf:1'b1};
      vecs[7] = '{a:8'h80, b:8'h01, cin:1'b0, sub:1'b1, sum:8'h7F, cout:1'b1, ovf:1'b1};

      rst_n = 1'b0;
      drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      drive(4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      set_ordy(1, 1'b0);
      set_ordy(4, 1'b0);
      #1;
      for (int w = 1; w <= 4; w += 3) begin
         get(w, ir, ov, s, co, of);
         check("reset_in_ready",  {31'd0, ir}, 32'd1);
         check("reset_out_valid", {31'd0, ov}, 32'd0);
         check("reset_sum",       {24'd0, s}, 32'd0);
         check("reset_cout",      {31'd0, co}, 32'd0);
         check("reset_ovf",       {31'd0, of}, 32'd0);
      end
      #11 rst_n = 1'b1;
      @(posedge clk); #1;

      // table-driven vectors on both slice widths
      for (int w = 1; w <= 4; w += 3) begin
         for (int i = 0; i < 8; i++) begin
            start_and_wait(w, vecs[i], $sformatf("vec%0d_bpc%0d", i, w));
            consume(w, $sformatf("vec%0d_bpc%0d", i, w));
         end
      end

      // backpressure: result held 5 cycles while inputs toggle
      start_and_wait(1, vecs[1], "bp");
      for (int k = 0; k < 5; k++) begin
         drive(1, k[0], 8'hA5 ^ 8'(k), 8'h3C + 8'(k), k[1], k[0]);
         @(posedge clk); #1;
         get(1, ir, ov, s, co, of);
         check("bp_out_valid", {31'd0, ov}, 32'd1);
         check("bp_in_ready",  {31'd0, ir}, 32'd0);
         check("bp_sum",       {24'd0, s}, 32'h80);
         check("bp_cout",      {31'd0, co}, 32'd0);
         check("bp_ovf",       {31'd0, of}, 32'd1);
      end
      consume(1, "bp");

      // reset in the middle of CALC, asynchronously between edges
      start_and_wait(1, vecs[0], "pre_rst");
      consume(1, "pre_rst");
      start_and_wait(1, vecs[2], "pre_rst2");
      consume(1, "pre_rst2");
      drive(1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      get(1, ir, ov, s, co, of);
      check("midrst_in_ready",  {31'd0, ir}, 32'd1);
      check("midrst_out_valid", {31'd0, ov}, 32'd0);
      check("midrst_sum",       {24'd0, s}, 32'd0);
      check("midrst_cout",      {31'd0, co}, 32'd0);
      check("midrst_ovf",       {31'd0, of}, 32'd0);
      #2 rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         get(1, ir, ov, s, co, of);
         if (ov) seen++;
      end
      check("midrst_no_out_valid", seen, 32'd0);
      check("midrst_idle_in_ready", {31'd0, ir}, 32'd1);

      // block still works after the abort
      start_and_wait(1, vecs[5], "post_rst");
      consume(1, "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands, processing BITS_PER_CYCLE bits per clock through a chain of full-adder slices, with a registered carry between cycles.
- Uses valid/ready handshakes on input and output.
- Sits between operand staging logic and the result consumer in the arithmetic datapath labs; intended as a small-area alternative to a wide ripple adder.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 2.
- BITS_PER_CYCLE, 1, bits processed per CALC cycle; must divide WIDTH exactly (elaboration-time assertion if not).
- Derived: N = WIDTH / BITS_PER_CYCLE, the number of CALC cycles; counter width is clog2(N)+1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = a+b+cin; 1 = a-b-cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result bits.
- cout  output  1  carry-out (add); NOT borrow-out (sub).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, counter=0, internal carry=0. Deassertion is synchronous to clk.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a, b, sub, and the initial carry, then go to CALC with counter=0.
  - Latched b is ~b if sub=1, else b.
  - Initial carry is ~cin if sub=1, else cin.
- CALC:
  - in_ready=0.
  - Each edge: slice [counter*BPC +: BPC] gets sum_i = a_i ^ b_i ^ c_i and c_(i+1) = (a_i&b_i) | (c_i&(a_i^b_i)), i.e. the true majority function.
  - Each edge: write the slice result, register the final carry, and increment the counter.
  - After the Nth CALC edge, go to DONE.
- DONE:
  - out_valid=1; sum, cout and ovf stable.
  - cout = final carry.
  - ovf = carry into MSB XOR carry out of MSB. The carry into the MSB is captured during the last slice.
  - On an edge with out_ready=1: go to IDLE with out_valid=0.
  - Held indefinitely while out_ready=0 (backpressure); outputs must not change.
- Latency: out_valid rises exactly N edges after the accepting edge. The minimum initiation interval is N+2 cycles.
- Input changes while in CALC or DONE are ignored, since operands are latched at acceptance.
- No same-cycle accept in DONE: in_ready=0 in DONE, and a new accept occurs at the earliest one cycle after the result handshake.
- in_ready and out_valid are never both 1.
- Wrap-around: sum is modulo 2^WIDTH. cout reports the carry out of that modulo sum.
- Reset mid-operation (CALC or DONE): the result is discarded and the block returns immediately to reset state. No out_valid pulse follows reset.
- BITS_PER_CYCLE=WIDTH: N=1, so out_valid rises one edge after accept.

Test Plan:
- Add with carry wrap (WIDTH=8, BPC=1): a=FF, b=01, cin=0, sub=0 -> sum=00, cout=1, ovf=0; out_valid exactly 8 edges after accept.
- Signed overflow: a=7F, b=01, cin=0, sub=0 -> sum=80, cout=0, ovf=1. Then a=80, b=FF, cin=0 -> sum=7F, cout=1, ovf=1.
- Subtract with borrow-in: a=05, b=07, cin=0, sub=1 -> sum=FE, cout=0, ovf=0. Then a=05, b=03, cin=1, sub=1 -> sum=01, cout=1.
- Carry-chain majority: a=FF, b=FF, cin=1, sub=0 -> sum=FF, cout=1.
  - Also rerun with BPC=4 (N=2): out_valid 2 edges after accept, identical result.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling a, b and in_valid throughout -> sum/cout/ovf stable and in_ready=0.
  - Result consumed on the first edge with out_ready=1; in_ready=1 in the next cycle.
- Reset mid-CALC: pulse rst_n low at CALC cycle 3, asynchronously between edges -> outputs go to reset values immediately, in_ready=1, and no out_valid is seen for the aborted operation.
